// File: rtl/final_pkg.sv
// Shared frame-buffer types and screen geometry for the ray-trace write path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package final_pkg;

   localparam int SCREEN_W     = 640;
   localparam int SCREEN_H     = 480;
   localparam int FB_LAST_ADDR = SCREEN_W * SCREEN_H - 1;

   // Pixel colour, packed {B,G,R}, 8 bits per channel.
   typedef logic [2:0][7:0] color;

   // Linear frame-buffer word address (covers 640x480 = 307200 words).
   typedef logic [18:0] fb_addr;

   // One queued write: address in the upper bits, colour in the lower bits.
   typedef struct packed {
      fb_addr addr;
      color   col;
   } pixel_entry;

endpackage

// File: rtl/pixel_fifo.sv
// Generic synchronous FIFO with registered level/full and storage cleared on reset.
// Latency: written entry is visible on rd_data the cycle after the push edge.
// Backpressure: push refused when full unless a pop happens in the same cycle; pop ignored when empty.
//
// Ports: clk, rst_n (async active-low), push/wr_data, pop/rd_data (head, combinational),
//        full, empty, level (0..DEPTH).
module pixel_fifo #(
   parameter int WIDTH = 43,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   // Pointers carry one extra wrap bit so equal indices can be told apart as full vs empty.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      level_q;
   logic [AW:0]      level_d;
   logic             full_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign do_push = push && (!full_q || do_pop);

   always_comb begin
      level_d = level_q;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         level_q <= level_d;
         full_q  <= (level_d == (AW+1)'(DEPTH));
      end
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign full    = full_q;
   assign level   = level_q;

endmodule

// File: rtl/pixel_write_queue.sv
// Elastic pixel write buffer: (x,y,colour) strobes -> linear address queue -> req/ack memory port.
// Latency: one cycle from WritePixel to Mem_req on an empty queue; one pop per cycle under constant ack.
// Backpressure: never stalls the producer; a strobe into a full queue with no pop is dropped and sets sticky Overflow.
//
// Ports: Clk, Reset_n (async active-low); WritePixel/WriteX/WriteY/Write_col (enqueue);
//        Mem_req/Mem_addr/Mem_data/Mem_ack (drain handshake); Queue_full, Level, Overflow, Frame_done.
// Build option: PWQ_BOUNDS_CHECK_EN drops off-screen strobes and adds the saturating Oob_count port.
module pixel_write_queue #(
   parameter int DEPTH    = 8,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     WritePixel,
   input  logic [9:0]               WriteX,
   input  logic [9:0]               WriteY,
   input  logic [23:0]              Write_col,
   output logic                     Mem_req,
   output logic [18:0]              Mem_addr,
   output logic [23:0]              Mem_data,
   input  logic                     Mem_ack,
   output logic                     Queue_full,
   output logic [$clog2(DEPTH):0]   Level,
   output logic                     Overflow,
   output logic                     Frame_done
`ifdef PWQ_BOUNDS_CHECK_EN
   ,
   output logic [15:0]              Oob_count
`endif
);

   import final_pkg::*;

   localparam int     LW        = $clog2(DEPTH) + 1;
   localparam fb_addr LAST_ADDR = fb_addr'(SCREEN_W * SCREEN_H - 1);

   typedef enum logic {
      ST_EMPTY  = 1'b0,
      ST_ACTIVE = 1'b1
   } drain_state_t;

   drain_state_t state_q;
   drain_state_t state_d;

   fb_addr     wr_addr;
   pixel_entry wr_entry;
   pixel_entry head;
   logic       fifo_full;
   logic       fifo_empty;
   logic [LW-1:0] fifo_level;
   logic       in_range;
   logic       push_req;
   logic       push_fire;
   logic       pop_fire;
   logic       overflow_q;
   logic       frame_done_q;

   // Full 19-bit arithmetic; out-of-range coordinates simply wrap.
   assign wr_addr  = fb_addr'(WriteY) * fb_addr'(SCREEN_W) + fb_addr'(WriteX);
   assign wr_entry = '{addr: wr_addr, col: color'(Write_col)};

`ifdef PWQ_BOUNDS_CHECK_EN
   assign in_range = (int'(WriteX) < SCREEN_W) && (int'(WriteY) < SCREEN_H);
`else
   assign in_range = 1'b1;
`endif

   assign push_req  = WritePixel && in_range;
   assign pop_fire  = Mem_req && Mem_ack;
   assign push_fire = push_req && (!fifo_full || pop_fire);

   pixel_fifo #(
      .WIDTH ($bits(pixel_entry)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (Clk),
      .rst_n   (Reset_n),
      .push    (push_req),
      .wr_data (wr_entry),
      .pop     (pop_fire),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (push_fire) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            // Only the last entry leaving with nothing arriving empties the queue.
            if (pop_fire && !push_fire && (fifo_level == LW'(1))) state_d = ST_EMPTY;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         if (push_req && !push_fire) overflow_q <= 1'b1;
         frame_done_q <= pop_fire && (head.addr == LAST_ADDR);
      end
   end

`ifdef PWQ_BOUNDS_CHECK_EN
   logic [15:0] oob_q;
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         oob_q <= '0;
      end else if (WritePixel && !in_range && (oob_q != 16'hFFFF)) begin
         oob_q <= oob_q + 16'd1;
      end
   end
   assign Oob_count = oob_q;
`endif

   assign Mem_req    = (fifo_level != '0);
   assign Mem_addr   = head.addr;
   assign Mem_data   = head.col;
   assign Queue_full = fifo_full;
   assign Level      = fifo_level;
   assign Overflow   = overflow_q;
   assign Frame_done = frame_done_q;

   // The explicit drain state must always mirror occupancy.
   a_state_tracks_level: assert property (@(posedge Clk) disable iff (!Reset_n)
      (state_q == ST_ACTIVE) == (fifo_level != '0) && (fifo_empty == (fifo_level == '0)));

endmodule

// File: tb/tb_pixel_write_queue.sv
// Self-checking bench for pixel_write_queue against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pixel_write_queue;

   localparam int DEPTH = 8;
   localparam int LAST  = 640 * 480 - 1;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        WritePixel = 1'b0;
   logic [9:0]  WriteX = '0;
   logic [9:0]  WriteY = '0;
   logic [23:0] Write_col = '0;
   logic        Mem_req;
   logic [18:0] Mem_addr;
   logic [23:0] Mem_data;
   logic        Mem_ack = 1'b0;
   logic        Queue_full;
   logic [3:0]  Level;
   logic        Overflow;
   logic        Frame_done;
`ifdef PWQ_BOUNDS_CHECK_EN
   logic [15:0] Oob_count;
`endif

   pixel_write_queue #(.DEPTH(DEPTH), .SCREEN_W(640), .SCREEN_H(480)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .WritePixel (WritePixel),
      .WriteX     (WriteX),
      .WriteY     (WriteY),
      .Write_col  (Write_col),
      .Mem_req    (Mem_req),
      .Mem_addr   (Mem_addr),
      .Mem_data   (Mem_data),
      .Mem_ack    (Mem_ack),
      .Queue_full (Queue_full),
      .Level      (Level),
      .Overflow   (Overflow),
      .Frame_done (Frame_done)
`ifdef PWQ_BOUNDS_CHECK_EN
      ,
      .Oob_count  (Oob_count)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int          addr;
      logic [23:0] col;
   } ent_t;

   ent_t mq[$];
   logic exp_ov;
   logic exp_fd;
   int   exp_oob;
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model: the queue of pending writes, advanced once per clock.
   task automatic cycle(input logic wp, input int x, input int y, input logic [23:0] c, input logic ack);
      logic pop, push, inb;
      WritePixel = wp;
      WriteX     = 10'(x);
      WriteY     = 10'(y);
      Write_col  = c;
      Mem_ack    = ack;
`ifdef PWQ_BOUNDS_CHECK_EN
      inb = (x < 640) && (y < 480);
`else
      inb = 1'b1;
`endif
      pop  = ack && (mq.size() != 0);
      push = wp && inb && ((mq.size() < DEPTH) || pop);
      exp_fd = pop && (mq[0].addr == LAST);
      if (wp && inb && !push) exp_ov = 1'b1;
      if (wp && !inb && exp_oob < 65535) exp_oob++;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{addr: (y * 640 + x) % (1 << 19), col: c});
      @(posedge Clk);
      #1;
      WritePixel = 1'b0;
      Mem_ack    = 1'b0;
   endtask

   task automatic apply_reset();
      Reset_n = 1'b0;
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      mq.delete();
      exp_ov  = 1'b0;
      exp_fd  = 1'b0;
      exp_oob = 0;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      #1;
      vectors++;
      if ({Mem_req, Queue_full, Overflow, Frame_done, Level} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_flags: got req/full/ov/fd/lvl=%b expected 00000000", {Mem_req, Queue_full, Overflow, Frame_done, Level});
      end
      vectors++;
      if ({Mem_addr, Mem_data} !== 43'h0) begin
         miscompares++;
         $display("FAIL reset_head: got addr=%0h data=%0h expected 0/0", Mem_addr, Mem_data);
      end
      apply_reset();
   endtask

   task automatic test_single();
      apply_reset();
      cycle(1'b1, 3, 2, 24'h00FF00, 1'b1);
      vectors++;
      if (Mem_req !== 1'b1 || Mem_addr !== 19'd1283 || Mem_data !== 24'h00FF00) begin
         miscompares++;
         $display("FAIL single_head: got req=%b addr=%0d data=%h expected 1/1283/00ff00", Mem_req, Mem_addr, Mem_data);
      end
      cycle(1'b0, 0, 0, 24'h0, 1'b1);
      vectors++;
      if (Mem_req !== 1'b0 || Level !== 4'd0) begin
         miscompares++;
         $display("FAIL single_drain: got req=%b level=%0d expected 0/0", Mem_req, Level);
      end
   endtask

   task automatic test_overflow();
      ent_t first[$];
      apply_reset();
      for (int i = 0; i < 9; i++) begin
         int x, y;
         logic [23:0] c;
         x = $urandom_range(639);
         y = $urandom_range(479);
         c = 24'($urandom);
         if (i < 8) first.push_back('{addr: y * 640 + x, col: c});
         cycle(1'b1, x, y, c, 1'b0);
         if (i == 7) begin
            vectors++;
            if (Queue_full !== 1'b1 || Overflow !== 1'b0 || Level !== 4'd8) begin
               miscompares++;
               $display("FAIL fill_8: got full=%b ov=%b level=%0d expected 1/0/8", Queue_full, Overflow, Level);
            end
         end
      end
      vectors++;
      if (Overflow !== 1'b1 || Level !== 4'd8) begin
         miscompares++;
         $display("FAIL overflow_9: got ov=%b level=%0d expected 1/8", Overflow, Level);
      end
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (Mem_req !== 1'b1 || Mem_addr !== 19'(first[i].addr) || Mem_data !== first[i].col) begin
            miscompares++;
            $display("FAIL drain_order[%0d]: got req=%b addr=%0d data=%h expected 1/%0d/%h", i, Mem_req, Mem_addr, Mem_data, first[i].addr, first[i].col);
         end
         cycle(1'b0, 0, 0, 24'h0, 1'b1);
      end
      vectors++;
      if (Level !== 4'd0 || Mem_req !== 1'b0 || Overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL drain_end: got level=%0d req=%b ov=%b expected 0/0/1", Level, Mem_req, Overflow);
      end
   endtask

   task automatic test_full_push_pop();
      apply_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, i, 1, 24'(i + 16), 1'b0);
      cycle(1'b1, 100, 200, 24'hABCDEF, 1'b1);
      vectors++;
      if (Level !== 4'd8 || Overflow !== 1'b0 || Queue_full !== 1'b1) begin
         miscompares++;
         $display("FAIL full_pushpop: got level=%0d ov=%b full=%b expected 8/0/1", Level, Overflow, Queue_full);
      end
      for (int i = 0; i < 7; i++) cycle(1'b0, 0, 0, 24'h0, 1'b1);
      vectors++;
      if (Level !== 4'd1 || Mem_addr !== 19'(200 * 640 + 100) || Mem_data !== 24'hABCDEF) begin
         miscompares++;
         $display("FAIL full_pushpop_last: got level=%0d addr=%0d data=%h expected 1/%0d/abcdef", Level, Mem_addr, Mem_data, 200 * 640 + 100);
      end
      cycle(1'b0, 0, 0, 24'h0, 1'b1);
   endtask

   task automatic test_frame_done();
      apply_reset();
      cycle(1'b1, 639, 479, 24'h123456, 1'b0);
      vectors++;
      if (Mem_addr !== 19'd307199 || Frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL frame_head: got addr=%0d fd=%b expected 307199/0", Mem_addr, Frame_done);
      end
      cycle(1'b0, 0, 0, 24'h0, 1'b1);
      vectors++;
      if (Frame_done !== 1'b1) begin
         miscompares++;
         $display("FAIL frame_pulse: got fd=%b expected 1", Frame_done);
      end
      cycle(1'b0, 0, 0, 24'h0, 1'b0);
      vectors++;
      if (Frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL frame_pulse_end: got fd=%b expected 0", Frame_done);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, i, 7, 24'(i), 1'b0);
      cycle(1'b0, 0, 0, 24'h0, 1'b1);
      Reset_n = 1'b0;
      #1;
      vectors++;
      if (Mem_req !== 1'b0 || Level !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_mid_async: got req=%b level=%0d expected 0/0", Mem_req, Level);
      end
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      mq.delete();
      exp_ov = 1'b0;
      exp_fd = 1'b0;
      exp_oob = 0;
      cycle(1'b0, 0, 0, 24'h0, 1'b1);
      vectors++;
      if (Mem_req !== 1'b0 || Level !== 4'd0 || Overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_ack: got req=%b level=%0d ov=%b expected 0/0/0", Mem_req, Level, Overflow);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int n = 0; n < 600; n++) begin
         int x, y, ack_pct;
         logic wp, ack;
         ack_pct = (n < 200) ? 30 : (n < 400) ? 90 : 55;
         wp  = ($urandom_range(99) < 60);
         ack = ($urandom_range(99) < ack_pct);
         if ($urandom_range(15) == 0) begin
            x = 639;
            y = 479;
         end else begin
            x = $urandom_range(639);
            y = $urandom_range(479);
         end
         cycle(wp, x, y, 24'($urandom), ack);
         vectors++;
         if (Level !== 4'(mq.size()) || Mem_req !== (mq.size() != 0) || Queue_full !== (mq.size() == DEPTH)
             || Overflow !== exp_ov || Frame_done !== exp_fd) begin
            miscompares++;
            $display("FAIL rand_status[%0d]: got level=%0d req=%b full=%b ov=%b fd=%b expected %0d/%b/%b/%b/%b",
                     n, Level, Mem_req, Queue_full, Overflow, Frame_done, mq.size(), mq.size() != 0, mq.size() == DEPTH, exp_ov, exp_fd);
         end
         if (mq.size() != 0) begin
            vectors++;
            if (Mem_addr !== 19'(mq[0].addr) || Mem_data !== mq[0].col) begin
               miscompares++;
               $display("FAIL rand_head[%0d]: got addr=%0d data=%h expected %0d/%h", n, Mem_addr, Mem_data, mq[0].addr, mq[0].col);
            end
         end
      end
   endtask

`ifdef PWQ_BOUNDS_CHECK_EN
   task automatic test_bounds();
      apply_reset();
      cycle(1'b1, 640, 0, 24'h111111, 1'b0);
      vectors++;
      if (Oob_count !== 16'(exp_oob) || Level !== 4'(mq.size()) || Overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL bounds_x: got oob=%0d level=%0d ov=%b expected %0d/%0d/0", Oob_count, Level, Overflow, exp_oob, mq.size());
      end
      cycle(1'b1, 0, 480, 24'h222222, 1'b0);
      vectors++;
      if (Oob_count !== 16'd2 || Level !== 4'd0) begin
         miscompares++;
         $display("FAIL bounds_y: got oob=%0d level=%0d expected 2/0", Oob_count, Level);
      end
   endtask
`endif

   initial begin
      exp_ov  = 1'b0;
      exp_fd  = 1'b0;
      exp_oob = 0;
      #2;
      test_reset();
      test_single();
      test_overflow();
      test_full_push_pop();
      test_frame_done();
      test_reset_mid();
      test_random();
`ifdef PWQ_BOUNDS_CHECK_EN
      test_bounds();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
